vector_loader: RTL and testbench

// - Upstream feeder for the dot-product multiplier cell: accepts a stream of INTSIZE-bit elements over a valid/ready

---
 rtl/vector_loader.sv | 144 ++++++++++++++
 tb/tb_vector_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// vector_loader: assembles a stream of INTSIZE-bit elements into vector A, then
// vector B, and holds the complete pair with vec_valid until the consumer
// acknowledges it with vec_ready.
// Optional feature: define VEC_LOADER_TIMEOUT_EN to add an idle counter that
// discards a partial load after TIMEOUT_CYCLES idle cycles and pulses timeout_err.
module vector_loader #(
   parameter int unsigned MATRIXSIZE     = 10,
   parameter int unsigned INTSIZE        = 8
`ifdef VEC_LOADER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [INTSIZE-1:0]                in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [0:INTSIZE*MATRIXSIZE-1]     a_flat,
   output logic [0:INTSIZE*MATRIXSIZE-1]     b_flat,
   output logic                              vec_valid,
   input  logic                              vec_ready
`ifdef VEC_LOADER_TIMEOUT_EN
   ,
   output logic                              timeout_err
`endif
);

   localparam int unsigned IdxW = (MATRIXSIZE > 1) ? $clog2(MATRIXSIZE) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(MATRIXSIZE - 1);

   typedef enum logic [1:0] {
      LoadA = 2'd0,
      LoadB = 2'd1,
      Hold  = 2'd2
   } state_t;

   state_t                           r_state;
   logic [IdxW-1:0]                  r_idx;
   logic [0:INTSIZE*MATRIXSIZE-1]    r_a_flat;
   logic [0:INTSIZE*MATRIXSIZE-1]    r_b_flat;
   logic                             r_vec_valid;
   logic                             w_xfer;
   logic                             w_timeout;

`ifdef VEC_LOADER_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] r_idle_cnt;
   logic            r_timeout_err;
   logic            w_partial;

   // A load is partial once A has started, or anywhere in B.
   always_comb begin
      w_partial = ((r_state == LoadA) && (r_idx != '0)) || (r_state == LoadB);
      w_timeout = w_partial && (r_idle_cnt == CntLast);
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout = 1'b0;
`endif

   // Ready is combinational so the source stalls in the same cycle the FSM holds.
   always_comb begin
      in_ready = (r_state != Hold) && !rst && !w_timeout;
      w_xfer   = in_valid && in_ready;
   end

   // Main FSM: element capture, pair hold and consumer handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LoadA;
         r_idx       <= '0;
         r_a_flat    <= '0;
         r_b_flat    <= '0;
         r_vec_valid <= 1'b0;
      end else if (w_timeout) begin
         // Buses are left as-is; only the load position is abandoned.
         r_state <= LoadA;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            LoadA: begin
               if (w_xfer) begin
                  r_a_flat[r_idx*INTSIZE +: INTSIZE] <= in_data;
                  if (r_idx == LastIdx) begin
                     r_idx   <= '0;
                     r_state <= LoadB;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            LoadB: begin
               if (w_xfer) begin
                  r_b_flat[r_idx*INTSIZE +: INTSIZE] <= in_data;
                  if (r_idx == LastIdx) begin
                     r_idx       <= '0;
                     r_state     <= Hold;
                     r_vec_valid <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            Hold: begin
               if (vec_ready) begin
                  r_state     <= LoadA;
                  r_vec_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= LoadA;
               r_idx       <= '0;
               r_vec_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef VEC_LOADER_TIMEOUT_EN
   // Idle counter: runs only while a load is partial, cleared by any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idle_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (w_timeout || w_xfer || !w_partial) begin
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
      end
   end
`endif

   assign a_flat    = r_a_flat;
   assign b_flat    = r_b_flat;
   assign vec_valid = r_vec_valid;

endmodule

// File: tb/tb_vector_loader.sv
// Bench for vector_loader with MATRIXSIZE=3, INTSIZE=8. Expected buses are
// built from the list of sent elements: the first three form A, the next three B.
module tb_vector_loader;

   localparam int MS = 3;
   localparam int W  = 8;

   logic              clk;
   logic              rst;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic [0:W*MS-1]   a_flat;
   logic [0:W*MS-1]   b_flat;
   logic              vec_valid;
   logic              vec_ready;
`ifdef VEC_LOADER_TIMEOUT_EN
   logic              timeout_err;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] el[2*MS];

   vector_loader #(
      .MATRIXSIZE    (MS),
      .INTSIZE       (W)
`ifdef VEC_LOADER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_flat     (a_flat),
      .b_flat     (b_flat),
      .vec_valid  (vec_valid),
      .vec_ready  (vec_ready)
`ifdef VEC_LOADER_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Element i of the vector starting at el[start] ends up i bytes from the MSB end.
   function automatic logic [W*MS-1:0] pack(input int start);
      logic [W*MS-1:0] v = '0;
      for (int i = 0; i < MS; i++) v = (v << W) | (W*MS)'(el[start+i]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_pair(input int max_gap);
      for (int i = 0; i < 2*MS; i++) begin
         repeat ($urandom_range(max_gap, 0)) tick();
         send(el[i]);
      end
   endtask

   task automatic check_pair(input string tag);
      int n = 0;
      @(negedge clk);
      while (!vec_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_vv"}, 64'(vec_valid), 64'd1);
      check({tag, "_a"}, 64'(a_flat), 64'(pack(0)));
      check({tag, "_b"}, 64'(b_flat), 64'(pack(MS)));
      check({tag, "_rdy"}, 64'(in_ready), 64'd0);
      tick();
   endtask

   task automatic ack(input string tag);
      repeat ($urandom_range(2, 0)) tick();
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      @(negedge clk);
      check({tag, "_ack_vv"}, 64'(vec_valid), 64'd0);
      check({tag, "_ack_rdy"}, 64'(in_ready), 64'd1);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("rst_vv", 64'(vec_valid), 64'd0);
      check("rst_a", 64'(a_flat), 64'd0);
      check("rst_b", 64'(b_flat), 64'd0);
      check("rst_rdy", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", 64'(in_ready), 64'd1);
      tick();
   endtask

   initial begin
      logic [W*MS-1:0] held_a;
      logic [W*MS-1:0] held_b;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      vec_ready = 1'b0;
      #1;

      // Reset behaviour.
      do_reset();

      // Basic back-to-back load.
      for (int i = 0; i < 2*MS; i++) el[i] = 8'(i + 1);
      send_pair(0);
      check_pair("basic");
      check("basic_dot", 64'(pack(0)), 64'h010203);

      // Backpressure while holding.
      held_a   = pack(0);
      held_b   = pack(MS);
      in_valid = 1'b1;
      in_data  = 8'h07;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_rdy", 64'(in_ready), 64'd0);
         check("bp_a", 64'(a_flat), 64'(held_a));
         check("bp_b", 64'(b_flat), 64'(held_b));
         tick();
      end
      vec_ready = 1'b1;
      @(negedge clk);
      check("bp_ackcyc_rdy", 64'(in_ready), 64'd0);
      check("bp_ackcyc_vv", 64'(vec_valid), 64'd1);
      tick();
      vec_ready = 1'b0;
      @(negedge clk);
      check("bp_after_vv", 64'(vec_valid), 64'd0);
      check("bp_after_rdy", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_el0", 64'(a_flat[0:7]), 64'h07);
      tick();

      // Gapped source after a fresh reset.
      do_reset();
      for (int i = 0; i < 2*MS; i++) begin
         tick();
         send(el[i]);
      end
      check_pair("gapped");
      ack("gapped");

      // Reset in the middle of a load.
      for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
      do_reset();
      for (int i = 0; i < 2*MS; i++) el[i] = 8'(8'h0A + i);
      send_pair(0);
      check_pair("midrst");
      ack("midrst");

`ifdef VEC_LOADER_TIMEOUT_EN
      // Partial load abandoned after the idle limit.
      begin
         int pulses = 0;
         send(8'h55);
         send(8'h66);
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (timeout_err) pulses++;
            tick();
         end
         check("to_pulses", 64'(pulses), 64'd1);
         for (int i = 0; i < 2*MS; i++) el[i] = 8'($urandom);
         send_pair(0);
         check_pair("to_clean");
         ack("to_clean");
      end
`else
      // Without the timeout a partial load simply waits.
      for (int i = 0; i < 2*MS; i++) el[i] = 8'($urandom);
      send(el[0]);
      send(el[1]);
      repeat (100) tick();
      for (int i = 2; i < 2*MS; i++) send(el[i]);
      check_pair("noto");
      ack("noto");
`endif

      // Randomized pairs with random source gaps and consumer delays.
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 2*MS; i++) el[i] = 8'($urandom);
         send_pair(2);
         check_pair("rand");
         ack("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
